// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - W-bit add/subtract sequenced one byte per cycle through a single 8-bit adder
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   s,
    output logic                  co,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry;
    logic [KW-1:0]   k;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      sum;
    logic            add_co;

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == KW'(i)) begin
                a_byte = a_reg[8*i +: 8];
                b_byte = b_reg[8*i +: 8];
            end
        end
    end

    // The one shared 8-bit adder; every byte slice goes through it.
    assign {add_co, sum} = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert b once at latch time.
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : ci;
                        k     <= '0;
                        s     <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (k == KW'(i)) s[8*i +: 8] <= sum;
                    end
                    carry <= add_co;
                    if (k == KLAST) begin
                        co    <= add_co;
                        ovf   <= a_reg[W-1] ^ b_reg[W-1] ^ sum[7] ^ add_co;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - scoreboard bench for multibyte_add_seq with NBYTES=4
module tb_multibyte_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];

    multibyte_add_seq #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic at full width: result, carry out, signed overflow.
    function automatic logic [33:0] model(input logic sb, input logic [31:0] av,
                                          input logic [31:0] bv, input logic c);
        logic [32:0] full;
        logic        ov;
        if (sb) begin
            full = {1'b0, av} + {1'b0, ~bv} + 33'd1;
            ov   = (av[31] != bv[31]) && (full[31] != av[31]);
        end else begin
            full = {1'b0, av} + {1'b0, bv} + {32'd0, c};
            ov   = (av[31] == bv[31]) && (full[31] != av[31]);
        end
        return {full[31:0], full[32], ov};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("result_s", {32'd0, s}, {32'd0, e[33:2]});
                check("result_co", {63'd0, co}, {63'd0, e[1]});
                check("result_ovf", {63'd0, ovf}, {63'd0, e[0]});
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Entered and left at #1 after a rising edge.
    task automatic run_op(input logic sb, input logic [31:0] av, input logic [31:0] bv, input logic c);
        int nbusy;
        int cyc;
        start = 1'b1; sub = sb; a = av; b = bv; ci = c;
        exp_q.push_back(model(sb, av, bv, c));
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = 0;
        cyc   = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_cycles", 64'(nbusy), 64'd4);
        check("done_latency", 64'(cyc), 64'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] done_pat;
        rst = 1'b1; start = 1'b1; sub = 1'b0; a = 32'hDEADBEEF; b = 32'h1; ci = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_s", {32'd0, s}, 64'd0);
        check("rst_co", {63'd0, co}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        @(posedge clk); #1;
        check("rst_no_start", {63'd0, busy}, 64'd0);

        run_op(1'b0, 32'h000000FF, 32'h00000001, 1'b0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        run_op(1'b0, 32'h12345678, 32'h11111111, 1'b1);
        run_op(1'b1, 32'h00000005, 32'h00000007, 1'b1);
        run_op(1'b1, 32'h00000007, 32'h00000005, 1'b1);
        run_op(1'b1, 32'h80000000, 32'h00000001, 1'b1);
        for (int i = 0; i < 4; i++)
            run_op(1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)));
        @(posedge clk); #1;

        // start held high: accepts at edges 0, 5, 10; done after edges 4, 9, 14.
        start = 1'b1; sub = 1'b0; a = 32'h01020304; b = 32'h10203040; ci = 1'b0;
        repeat (3) exp_q.push_back(model(1'b0, 32'h01020304, 32'h10203040, 1'b0));
        done_pat = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == 10) start = 1'b0;
            done_pat[i] = done;
        end
        check("backtoback_done_pattern", {48'd0, done_pat}, 64'h4210);
        repeat (2) @(posedge clk);
        #1;

        // Start pulse and operand changes during RUN must not disturb the result.
        start = 1'b1; sub = 1'b0; a = 32'h00000001; b = 32'h00000002; ci = 1'b0;
        exp_q.push_back(model(1'b0, 32'h00000001, 32'h00000002, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b1; a = 32'hFFFF0000; b = 32'h12345678; ci = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ignore_done", {63'd0, done}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_s", {32'd0, s}, 64'h3);
            check("hold_co_ovf", {62'd0, co, ovf}, 64'd0);
        end
        check("hold_idle", {62'd0, busy, done}, 64'd0);

        // Reset during the second RUN cycle aborts the operation.
        start = 1'b1; sub = 1'b0; a = 32'hFFFFFFFF; b = 32'h00000001; ci = 1'b0;
        exp_q.push_back(model(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_s", {32'd0, s}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op(1'b1, 32'h00000000, 32'h00000001, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
Sequencer that performs W-bit add/subtract (W = 8*NBYTES) by time-multiplexing a single 8-bit ripple adder (a + b + ci -> s, co), one byte per cycle, LSB byte first.
- Carry is held in a register between byte steps.
- Sits between a requester and the 8-bit adder datapath: latches operands, steps byte index, collects result, reports carry and signed overflow.
- Exactly one 8-bit adder instance; no wider adder permitted.

Parameters:
NBYTES, 4, number of 8-bit slices per operand (>=1); W = 8*NBYTES derived, not overridable.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = a+b+ci, 1 = a-b (b inverted, carry-in forced 1, ci ignored)
a  input  W  operand A, latched on accepted start
b  input  W  operand B, latched on accepted start
ci  input  1  carry-in for add, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE
s  output  W  result; held stable from done until next accepted start
co  output  1  final carry out (sub: 1 = no borrow)
ovf  output  1  signed overflow of W-bit operation

Behaviour:
- Reset (rst=1 at edge): state=IDLE, byte index k=0, carry reg=0, s=0, co=0, ovf=0, busy=0, done=0. Reset wins over all other inputs.
- Reset mid-RUN aborts: no done pulse, partial s discarded (cleared to 0).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> latch a_reg=a, b_reg=(sub ? ~b : b), carry=(sub ? 1 : ci), k=0, s=0 -> RUN.
  - start=0 -> stay; s/co/ovf hold.
- RUN, each edge:
  - Adder inputs: a_reg[8k+7:8k], b_reg[8k+7:8k], carry.
  - Write adder sum into s[8k+7:8k]; carry <= adder co.
  - If k==NBYTES-1: co <= adder co; ovf <= a_reg[W-1] ^ b_reg[W-1] ^ sum[7] ^ adder co (carry into MSB xor carry out); -> DONE.
  - Otherwise k <= k+1.
  - start ignored. Input operand changes ignored (latched copies used).
- DONE: done=1 for exactly this cycle, busy=0.
  - start=1 -> accept as in IDLE (back-to-back, no idle bubble) -> RUN.
  - Otherwise -> IDLE.
- busy = (state==RUN); combinational from state register only. done = (state==DONE).
- Latency: start sampled at edge E0 -> busy high for cycles after E0..E(NBYTES) -> done high in cycle after E(NBYTES). Throughput: one op per NBYTES+1 cycles.
- s bytes already computed during RUN may be visible; s is valid only when done=1 and afterwards until next accepted start.
- NBYTES=1: single RUN cycle, then DONE.
- Index k wraps to 0 only via accepted start or reset; it never exceeds NBYTES-1.
- No X propagation: all state registers are reset.

Test Plan:
- Reset: assert rst 2 cycles with start=1 -> busy=0, done=0, s=0x00000000, co=0, ovf=0; no operation starts.
- Carry ripple across bytes (NBYTES=4): a=0x000000FF, b=0x00000001, ci=0, sub=0 -> busy high exactly 4 cycles; done on 5th cycle after start edge; s=0x00000100, co=0, ovf=0.
- Full wrap and signed overflow: a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, co=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, co=0, ovf=1. Then a=0x12345678, b=0x11111111, ci=1 -> s=0x2345678A, co=0.
- Subtract: sub=1, ci=1, a=5, b=7 -> s=0xFFFFFFFE, co=0, ovf=0. Then a=7, b=5 -> s=0x00000002, co=1. Then a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1.
- Handshake:
  - start held high continuously -> back-to-back ops, done pulses every 5 cycles.
  - start pulse and operand changes during RUN -> ignored, result unchanged.
  - s/co/ovf stable across 10 idle cycles after done.
- Reset mid-operation: rst at 2nd RUN cycle of a=0xFFFFFFFF+1 -> next cycle IDLE, busy=0, s=0; no done pulse; subsequent start completes correctly.
